// File: rtl/qpi_wb_slave_bridge_if.sv
// Bus bundle between a pipelined Wishbone master and the QPI memory-controller
// front end; the bridge uses the slave view, the bus owner the master view.
interface qpi_wb_slave_bridge_if #(
  parameter int AW = 24,
  parameter int DW = 32
) ();

  logic            i_wb_cyc;
  logic            i_wb_stb;
  logic            i_wb_we;
  logic [AW-1:0]   i_wb_addr;
  logic [DW/8-1:0] i_wb_sel;
  logic [DW-1:0]   i_wb_data;
  logic            o_wb_ack;
  logic            o_wb_stall;
  logic [DW-1:0]   o_wb_data;

  logic            qpi_do_read;
  logic            qpi_do_write;
  logic [AW-1:0]   qpi_addr;
  logic [DW-1:0]   qpi_wdata;
  logic [DW-1:0]   qpi_rdata;
  logic            qpi_next_word;
  logic            qpi_is_idle;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data,
    output qpi_do_read, qpi_do_write, qpi_addr, qpi_wdata,
    input  qpi_rdata, qpi_next_word, qpi_is_idle
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data,
    input  qpi_do_read, qpi_do_write, qpi_addr, qpi_wdata,
    output qpi_rdata, qpi_next_word, qpi_is_idle
  );

endinterface

// File: rtl/qpi_wb_slave_bridge.sv
// Wishbone pipelined slave feeding a QPI memory controller: one pending slot,
// one in-flight word, and burst continuation for contiguous same-direction words.
module qpi_wb_slave_bridge #(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int ADDR_INC = 2
) (
  input logic                  clk,
  input logic                  rst,
  qpi_wb_slave_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;

  logic          pend_valid_r;
  logic          pend_we_r;
  logic [AW-1:0] pend_addr_r;
  logic [DW-1:0] pend_data_r;

  logic          cur_we_r;
  logic [AW-1:0] cur_addr_r;
  logic [DW-1:0] cur_data_r;

  logic          ack_r;
  logic [DW-1:0] rdata_r;
  logic          do_read_r;
  logic          do_write_r;

  logic          accept_s;
  logic          launch_s;
  logic          cont_s;
  logic          word_done_s;
  logic          burst_match_s;
  logic          we_nxt_s;
  logic [AW-1:0] next_addr_s;

  // Requests land only in an empty slot, so loading and draining the slot never coincide.
  assign accept_s      = bus.i_wb_cyc & bus.i_wb_stb & ~pend_valid_r;
  assign next_addr_s   = cur_addr_r + AW'(ADDR_INC);
  assign burst_match_s = pend_valid_r & (pend_we_r == cur_we_r) &
                         (pend_addr_r == next_addr_s) & bus.i_wb_cyc;
  assign we_nxt_s      = (launch_s | cont_s) ? pend_we_r : cur_we_r;

  // Next-state and transfer strobes.
  always_comb begin
    state_nxt_s = state_r;
    launch_s    = 1'b0;
    cont_s      = 1'b0;
    word_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_valid_r && bus.qpi_is_idle && bus.i_wb_cyc) begin
          launch_s    = 1'b1;
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (bus.qpi_next_word) begin
          word_done_s = 1'b1;
          if (burst_match_s) begin
            cont_s      = 1'b1;
            state_nxt_s = ACTIVE;
          end else begin
            state_nxt_s = DRAIN;
          end
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      DRAIN: begin
        // do_* is already low during the first DRAIN cycle, so IDLE is never
        // reached before the controller has seen the strobe fall.
        if (bus.qpi_is_idle) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pending slot: filled on accept, emptied on launch/continuation or when the cycle ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_r <= 1'b0;
      pend_we_r    <= 1'b0;
      pend_addr_r  <= {AW{1'b0}};
      pend_data_r  <= {DW{1'b0}};
    end else if (accept_s) begin
      pend_valid_r <= 1'b1;
      pend_we_r    <= bus.i_wb_we;
      pend_addr_r  <= bus.i_wb_addr;
      pend_data_r  <= bus.i_wb_data;
    end else if (launch_s || cont_s || !bus.i_wb_cyc) begin
      pend_valid_r <= 1'b0;
    end
  end

  // Current-transfer register drives the controller address and write data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_we_r   <= 1'b0;
      cur_addr_r <= {AW{1'b0}};
      cur_data_r <= {DW{1'b0}};
    end else if (launch_s || cont_s) begin
      cur_we_r   <= pend_we_r;
      cur_addr_r <= pend_addr_r;
      cur_data_r <= pend_data_r;
    end
  end

  // Controller strobes follow the state entered at this edge and its direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      do_read_r  <= 1'b0;
      do_write_r <= 1'b0;
    end else begin
      do_read_r  <= (state_nxt_s == ACTIVE) & ~we_nxt_s;
      do_write_r <= (state_nxt_s == ACTIVE) &  we_nxt_s;
    end
  end

  // Wishbone response: ack only if the master still owns the cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r   <= 1'b0;
      rdata_r <= {DW{1'b0}};
    end else begin
      ack_r <= word_done_s & bus.i_wb_cyc;
      if (word_done_s && !cur_we_r) begin
        rdata_r <= bus.qpi_rdata;
      end
    end
  end

  assign bus.o_wb_ack     = ack_r;
  assign bus.o_wb_stall   = pend_valid_r;
  assign bus.o_wb_data    = rdata_r;
  assign bus.qpi_do_read  = do_read_r;
  assign bus.qpi_do_write = do_write_r;
  assign bus.qpi_addr     = cur_addr_r;
  assign bus.qpi_wdata    = cur_data_r;

endmodule

// File: tb/tb_qpi_wb_slave_bridge.sv
// Self-checking bench: directed bridge scenarios plus randomized Wishbone
// traffic against a reactive QPI controller, checked against a behavioural model.
module tb_qpi_wb_slave_bridge;

  localparam int AW       = 24;
  localparam int DW       = 32;
  localparam int ADDR_INC = 2;
  localparam int M_IDLE   = 0;
  localparam int M_ACT    = 1;
  localparam int M_DRAIN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  qpi_wb_slave_bridge_if #(.AW(AW), .DW(DW)) bus ();

  qpi_wb_slave_bridge #(.AW(AW), .DW(DW), .ADDR_INC(ADDR_INC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int            m_mode;
  logic          m_pv, m_pwe, m_cwe, m_ack;
  logic [AW-1:0] m_pa, m_ca;
  logic [DW-1:0] m_pd, m_cd, m_rdat;

  // observation records
  int            ack_cnt, rise_cnt;
  logic          prev_busy;
  logic [DW-1:0] ack_data_q[$];
  logic [AW-1:0] nw_addr_q[$];
  logic [DW-1:0] nw_wdata_q[$];
  logic          rise_we_q[$];

  // reactive controller
  logic ctrl_auto;
  logic c_was_busy;
  int   c_cnt, c_idle_cnt, lat_min, lat_max;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {8'h5A, a} ^ 32'h0F0F_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pv = 1'b0; m_pwe = 1'b0; m_pa = '0; m_pd = '0;
    m_cwe = 1'b0; m_ca = '0; m_cd = '0;
    m_ack = 1'b0; m_rdat = '0;
  endtask

  // Expected post-edge outputs from the inputs presented in the current cycle.
  task automatic model_update();
    logic take, acc;
    int   want;
    if (!rst) begin
      model_reset();
      return;
    end
    acc   = bus.i_wb_cyc && bus.i_wb_stb && !m_pv;
    take  = 1'b0;
    m_ack = 1'b0;
    if (m_mode == M_IDLE) begin
      if (m_pv && bus.qpi_is_idle && bus.i_wb_cyc) begin
        take = 1'b1;
        m_mode = M_ACT;
      end
    end else if (m_mode == M_ACT) begin
      if (bus.qpi_next_word) begin
        m_ack = bus.i_wb_cyc;
        if (!m_cwe) m_rdat = bus.qpi_rdata;
        want = (int'(m_ca) + ADDR_INC) % (1 << AW);
        if (m_pv && bus.i_wb_cyc && (m_pwe == m_cwe) && (int'(m_pa) == want)) take = 1'b1;
        else m_mode = M_DRAIN;
      end
    end else begin
      if (bus.qpi_is_idle) m_mode = M_IDLE;
    end
    if (take) begin
      m_cwe = m_pwe; m_ca = m_pa; m_cd = m_pd; m_pv = 1'b0;
    end
    if (acc) begin
      m_pv = 1'b1; m_pwe = bus.i_wb_we; m_pa = bus.i_wb_addr; m_pd = bus.i_wb_data;
    end else if (!bus.i_wb_cyc) begin
      m_pv = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("ack",       bus.o_wb_ack,     m_ack);
    chk("stall",     bus.o_wb_stall,   m_pv);
    chk("wb_data",   bus.o_wb_data,    m_rdat);
    chk("do_read",   bus.qpi_do_read,  (m_mode == M_ACT) && !m_cwe);
    chk("do_write",  bus.qpi_do_write, (m_mode == M_ACT) && m_cwe);
    chk("qpi_addr",  bus.qpi_addr,     m_ca);
    chk("qpi_wdata", bus.qpi_wdata,    m_cd);
  endtask

  task automatic monitor();
    logic busy;
    busy = bus.qpi_do_read | bus.qpi_do_write;
    if (bus.o_wb_ack) begin
      ack_cnt++;
      ack_data_q.push_back(bus.o_wb_data);
    end
    if (busy && !prev_busy) begin
      rise_cnt++;
      rise_we_q.push_back(bus.qpi_do_write);
    end
    prev_busy = busy;
  endtask

  task automatic clear_mon();
    ack_cnt = 0; rise_cnt = 0;
    ack_data_q.delete(); nw_addr_q.delete(); nw_wdata_q.delete(); rise_we_q.delete();
  endtask

  // Controller: word done lat cycles after launch/previous word; busy until do_* falls.
  task automatic ctrl_drive();
    logic busy;
    if (!ctrl_auto) return;
    busy = bus.qpi_do_read | bus.qpi_do_write;
    if (busy) begin
      if (!c_was_busy) c_cnt = $urandom_range(lat_max, lat_min);
      if (c_cnt == 0) begin
        bus.qpi_next_word = 1'b1;
        nw_addr_q.push_back(bus.qpi_addr);
        nw_wdata_q.push_back(bus.qpi_wdata);
        c_cnt = $urandom_range(lat_max, lat_min);
      end else begin
        bus.qpi_next_word = 1'b0;
        c_cnt--;
      end
      bus.qpi_is_idle = 1'b0;
      c_idle_cnt = $urandom_range(2, 0);
    end else begin
      bus.qpi_next_word = 1'b0;
      if (c_idle_cnt > 0) begin
        bus.qpi_is_idle = 1'b0;
        c_idle_cnt--;
      end else begin
        bus.qpi_is_idle = 1'b1;
      end
    end
    bus.qpi_rdata = mem_word(bus.qpi_addr);
    c_was_busy = busy;
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    check_outputs();
    monitor();
    ctrl_drive();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Present one request and hold it until the bridge takes it.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = we;
    bus.i_wb_addr = a; bus.i_wb_data = d; bus.i_wb_sel = DW'($urandom) >> (DW - DW/8);
    for (int k = 0; k < 100; k++) begin
      acc = !bus.o_wb_stall;
      step();
      if (acc) return;
    end
    chk("send_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    logic acc;
    logic last_we;
    logic [AW-1:0] last_a;
    int drop_cnt;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    bus.i_wb_addr = '0; bus.i_wb_sel = '0; bus.i_wb_data = '0;
    bus.qpi_rdata = '0; bus.qpi_next_word = 1'b0; bus.qpi_is_idle = 1'b1;
    ctrl_auto = 1'b0; c_was_busy = 1'b0; c_cnt = 0; c_idle_cnt = 0;
    lat_min = 1; lat_max = 2; prev_busy = 1'b0;
    clear_mon();
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    check_outputs();
    chk("rst_stall", bus.o_wb_stall, 1'b0);
    rst = 1'b1;

    // single read at 0x000100 with a hand-driven controller
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0; bus.i_wb_addr = 24'h000100;
    step();
    chk("t1_stall", bus.o_wb_stall, 1'b1);
    bus.i_wb_stb = 1'b0;
    step();
    chk("t2_do_read", bus.qpi_do_read, 1'b1);
    chk("t2_addr", bus.qpi_addr, 24'h000100);
    bus.qpi_is_idle = 1'b0; bus.qpi_next_word = 1'b1; bus.qpi_rdata = 32'hDEAD_BEEF;
    step();
    chk("n1_ack", bus.o_wb_ack, 1'b1);
    chk("n1_data", bus.o_wb_data, 32'hDEAD_BEEF);
    chk("n1_do_read", bus.qpi_do_read, 1'b0);
    bus.qpi_next_word = 1'b0; bus.qpi_is_idle = 1'b1;
    step();
    chk("n2_ack", bus.o_wb_ack, 1'b0);
    run(2);

    // four-word write burst
    ctrl_auto = 1'b1;
    clear_mon();
    send(1'b1, 24'h000010, 32'hA000_0010);
    send(1'b1, 24'h000012, 32'hA000_0012);
    send(1'b1, 24'h000014, 32'hA000_0014);
    send(1'b1, 24'h000016, 32'hA000_0016);
    bus.i_wb_stb = 1'b0;
    run(20);
    chk("burst_acks", ack_cnt, 4);
    chk("burst_launches", rise_cnt, 1);
    chk("burst_words", nw_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < nw_addr_q.size(); i++) begin
      chk("burst_addr", nw_addr_q[i], 24'h000010 + 24'(2 * i));
      chk("burst_wdata", nw_wdata_q[i], 32'hA000_0010 + 32'(2 * i));
    end

    // read 0x20 then non-contiguous read 0x30
    clear_mon();
    send(1'b0, 24'h000020, 32'h0);
    send(1'b0, 24'h000030, 32'h0);
    bus.i_wb_stb = 1'b0;
    run(25);
    chk("rr_launches", rise_cnt, 2);
    chk("rr_acks", ack_data_q.size(), 2);
    if (ack_data_q.size() >= 2) begin
      chk("rr_data0", ack_data_q[0], 32'h550F_0F2F);
      chk("rr_data1", ack_data_q[1], 32'h550F_0F3F);
    end

    // read 0x40 then write 0x42: direction change ends the burst
    clear_mon();
    send(1'b0, 24'h000040, 32'h0);
    send(1'b1, 24'h000042, 32'hCAFE_0042);
    bus.i_wb_stb = 1'b0;
    run(25);
    chk("rw_launches", rise_cnt, 2);
    chk("rw_acks", ack_data_q.size(), 2);
    if (rise_we_q.size() >= 2 && ack_data_q.size() >= 1 && nw_wdata_q.size() >= 2) begin
      chk("rw_dir0", rise_we_q[0], 1'b0);
      chk("rw_dir1", rise_we_q[1], 1'b1);
      chk("rw_rdata", ack_data_q[0], 32'h550F_0F4F);
      chk("rw_wdata", nw_wdata_q[1], 32'hCAFE_0042);
    end

    // cycle abort while ACTIVE with the pending slot full
    lat_min = 3; lat_max = 3;
    clear_mon();
    send(1'b0, 24'h000050, 32'h0);
    send(1'b0, 24'h000052, 32'h0);
    chk("abort_pend_full", bus.o_wb_stall, 1'b1);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    step();
    chk("abort_pend_clr", bus.o_wb_stall, 1'b0);
    run(15);
    chk("abort_acks", ack_cnt, 0);
    chk("abort_launches", rise_cnt, 1);
    chk("abort_idle_rd", bus.qpi_do_read, 1'b0);

    // reset in the middle of a write burst
    lat_min = 2; lat_max = 3;
    send(1'b1, 24'h000070, 32'h1234_0070);
    send(1'b1, 24'h000072, 32'h1234_0072);
    for (int k = 0; k < 10 && !bus.qpi_do_write; k++) step();
    chk("rst_burst_live", bus.qpi_do_write, 1'b1);
    rst = 1'b0;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_do_write", bus.qpi_do_write, 1'b0);
    chk("rst_stall2", bus.o_wb_stall, 1'b0);
    run(2);
    rst = 1'b1;
    clear_mon();
    send(1'b0, 24'h000060, 32'h0);
    bus.i_wb_stb = 1'b0;
    run(15);
    chk("post_rst_acks", ack_cnt, 1);
    if (ack_data_q.size() >= 1) chk("post_rst_data", ack_data_q[0], 32'h550F_0F6F);

    // randomized traffic
    lat_min = 1; lat_max = 3;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b0;
    last_a = 24'hFFFFF8; last_we = 1'b0; drop_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      acc = bus.i_wb_cyc && bus.i_wb_stb && !bus.o_wb_stall;
      step();
      if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) bus.i_wb_cyc = 1'b1;
      end else if ($urandom_range(99, 0) < 2) begin
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
        drop_cnt = $urandom_range(4, 1);
      end else if (!bus.i_wb_stb || acc) begin
        if ($urandom_range(3, 0) == 0) begin
          bus.i_wb_stb = 1'b0;
        end else begin
          int r;
          r = $urandom_range(9, 0);
          if (r < 6) begin
            last_a = last_a + 24'(ADDR_INC);
          end else if (r < 7) begin
            last_a = last_a + 24'(ADDR_INC); last_we = ~last_we;
          end else if (r < 8) begin
            last_a = 24'hFFFFFE;
          end else begin
            last_a = AW'($urandom); last_we = 1'($urandom);
          end
          bus.i_wb_stb = 1'b1; bus.i_wb_we = last_we; bus.i_wb_addr = last_a;
          bus.i_wb_data = $urandom; bus.i_wb_sel = 4'($urandom);
        end
      end
    end
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
